div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 SHALL have input clk, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have input rst_n, 1 bit: reset is synchronous and active-low.
REQ-004 SHALL have input StartE, 1 bit: execute stage issues a divide/remainder op this cycle.
REQ-005 SHALL have input DivOpE, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have input SrcAE, XLEN bits: dividend.
REQ-007 SHALL have input SrcBE, XLEN bits: divisor.
REQ-008 SHALL have input RdE, 5 bits: destination register of the issued op.
REQ-009 SHALL have input KillF, 1 bit: abort the in-flight op (branch flush).
REQ-010 SHALL have output BusyF, 1 bit: pipeline must stall; feeds hazard unit StallF/StallD.
REQ-011 SHALL have output DoneF, 1 bit: ResultF/RdF valid this cycle; one-cycle pulse.
REQ-012 SHALL have output ResultF, XLEN bits: quotient or remainder.
REQ-013 SHALL have output RdF, 5 bits: destination register of the completed op.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 IDLE: StartE=1 and KillF=0 SHALL accept op, latch DivOpE, RdE, operand magnitudes and result-sign flags.
REQ-016 Accept with SrcBE=0 or signed overflow (DIV/REM, SrcAE=0x80000000, SrcBE=0xFFFFFFFF) SHALL go IDLE->DONE; all others IDLE->CALC.
REQ-017 CALC SHALL run radix-2 restoring division, one quotient bit per cycle: shift {rem,quot} left 1, subtract divisor from rem when non-negative result, set quot LSB accordingly.
REQ-018 CALC SHALL last exactly XLEN cycles via a cycle counter, then transition to DONE.
REQ-019 DONE SHALL assert DoneF for exactly one cycle, then return to IDLE unconditionally.
REQ-020 BusyF SHALL equal (state==CALC) OR (state==IDLE AND StartE AND NOT KillF), combinational; BusyF=0 in DONE.
REQ-021 Normal latency: accept at cycle T, DoneF at T+XLEN+1; BusyF high T..T+XLEN.
REQ-022 Special-case latency: accept at T, DoneF at T+1; BusyF high at T only.
REQ-023 Signed ops SHALL divide magnitudes; quotient negated if operand signs differ; remainder takes dividend sign.
REQ-024 Divide by zero SHALL give quotient all-ones and remainder equal to SrcAE, for signed and unsigned.
REQ-025 Signed overflow SHALL give quotient 0x80000000 and remainder 0.
REQ-026 ResultF SHALL be quotient for DIV/DIVU, remainder for REM/REMU; ResultF and RdF SHALL hold their value from DONE until the next DONE.
REQ-027 StartE in CALC or DONE SHALL be ignored; no queueing.
REQ-028 KillF=1 in any state SHALL force IDLE next cycle with no DoneF; KillF together with StartE in IDLE SHALL reject the op.
REQ-029 DoneF SHALL never assert without a prior accepted, unkilled op.

Reset
REQ-030 rst_n=0 at a rising clk edge SHALL set state IDLE, counter 0, DoneF=0, ResultF=0, RdF=0, regardless of state.
REQ-031 During reset, BusyF SHALL be 0.
REQ-032 Reset mid-CALC SHALL discard the op; no DoneF after release.

Verification
REQ-033 DIVU 100/7, RdE=5, accept T -> BusyF high T..T+32, DoneF at T+33, ResultF=14, RdF=5; REMU same -> 2.
REQ-034 DIV 0xFFFFFFF9 (-7)/2 -> ResultF=0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-035 DIVU 0x1234/0 -> DoneF at T+1, ResultF=0xFFFFFFFF; REM 0x1234/0 -> 0x1234.
REQ-036 DIV 0x80000000/0xFFFFFFFF -> DoneF at T+1, ResultF=0x80000000; REM -> 0.
REQ-037 KillF at T+10 of a normal op -> IDLE at T+11, BusyF=0 at T+11, no DoneF; new StartE at T+11 accepted.
REQ-038 rst_n=0 at T+5 of a normal op -> all outputs 0 next cycle, no DoneF afterwards; StartE during CALC ignored, result unaffected.

Source files
------------

// File: rtl/div_unit.sv
// Iterative integer divider for the RV32M DIV/DIVU/REM/REMU ops.
// Radix-2 restoring division produces one quotient bit per cycle. Divide-by-zero
// and signed overflow skip the iteration and complete on the following cycle.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StartE,
    input  logic [1:0]      DivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic [4:0]      RdE,
    input  logic            KillF,
    output logic            BusyF,
    output logic            DoneF,
    output logic [XLEN-1:0] ResultF,
    output logic [4:0]      RdF
);

    localparam int unsigned     CntW    = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinVal  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } divState_e;

    divState_e       stateQ, stateD;
    logic [CntW-1:0] cntQ, cntD;
    logic [XLEN-1:0] remQ, remD;
    logic [XLEN-1:0] quotQ, quotD;
    logic [XLEN-1:0] divisorQ, divisorD;
    logic            isRemQ, isRemD;
    logic            quotNegQ, quotNegD;
    logic            remNegQ, remNegD;
    logic [4:0]      rdQ, rdD;
    logic [4:0]      rdOutQ, rdOutD;
    logic [XLEN-1:0] resultQ, resultD;

    // Operand decode for the op being offered this cycle.
    logic            opSigned, opIsRem, accept;
    logic            divByZero, signedOvf, special;
    logic            aNeg, bNeg;
    logic [XLEN-1:0] aMag, bMag, specialResult;

    assign opSigned  = ~DivOpE[0];
    assign opIsRem   = DivOpE[1];
    assign accept    = (stateQ == StIdle) & StartE & ~KillF;
    assign divByZero = (SrcBE == '0);
    assign signedOvf = opSigned & (SrcAE == MinVal) & (SrcBE == '1);
    assign special   = divByZero | signedOvf;
    assign aNeg      = opSigned & SrcAE[XLEN-1];
    assign bNeg      = opSigned & SrcBE[XLEN-1];
    assign aMag      = aNeg ? -SrcAE : SrcAE;
    assign bMag      = bNeg ? -SrcBE : SrcBE;

    // Divide by zero: quotient all-ones, remainder is the dividend.
    // Signed overflow: quotient is the most negative value, remainder zero.
    assign specialResult = divByZero ? (opIsRem ? SrcAE : '1)
                                     : (opIsRem ? '0 : MinVal);

    // One restoring step: shift {rem,quot} left, keep the difference if it did not borrow.
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] stepRem, stepQuot, finalQuot, finalRem;

    assign shifted   = {remQ, quotQ[XLEN-1]};
    assign diff      = shifted - {1'b0, divisorQ};
    assign stepRem   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign stepQuot  = {quotQ[XLEN-2:0], ~diff[XLEN]};
    assign finalQuot = quotNegQ ? -stepQuot : stepQuot;
    assign finalRem  = remNegQ ? -stepRem : stepRem;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic and handshake outputs; a kill overrides every transition.
    always_comb begin
        stateD = stateQ;
        BusyF  = 1'b0;
        DoneF  = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (accept) begin
                    stateD = special ? StDone : StCalc;
                end
                BusyF = rst_n & accept;
            end
            StCalc: begin
                if (cntQ == CntLast) begin
                    stateD = StDone;
                end
                BusyF = rst_n;
            end
            StDone: begin
                stateD = StIdle;
                DoneF  = 1'b1;
            end
            default: stateD = StIdle;
        endcase
        if (KillF) begin
            stateD = StIdle;
        end
    end

    // Datapath next-state: latch operands on accept, iterate in CALC, capture result on completion.
    always_comb begin
        cntD     = cntQ;
        remD     = remQ;
        quotD    = quotQ;
        divisorD = divisorQ;
        isRemD   = isRemQ;
        quotNegD = quotNegQ;
        remNegD  = remNegQ;
        rdD      = rdQ;
        rdOutD   = rdOutQ;
        resultD  = resultQ;
        unique case (stateQ)
            StIdle: begin
                if (accept) begin
                    cntD     = '0;
                    remD     = '0;
                    quotD    = aMag;
                    divisorD = bMag;
                    isRemD   = opIsRem;
                    quotNegD = aNeg ^ bNeg;
                    remNegD  = aNeg;
                    rdD      = RdE;
                    if (special) begin
                        resultD = specialResult;
                        rdOutD  = RdE;
                    end
                end
            end
            StCalc: begin
                cntD  = cntQ + CntW'(1);
                remD  = stepRem;
                quotD = stepQuot;
                if ((cntQ == CntLast) && !KillF) begin
                    resultD = isRemQ ? finalRem : finalQuot;
                    rdOutD  = rdQ;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cntQ     <= '0;
            remQ     <= '0;
            quotQ    <= '0;
            divisorQ <= '0;
            isRemQ   <= 1'b0;
            quotNegQ <= 1'b0;
            remNegQ  <= 1'b0;
            rdQ      <= '0;
            rdOutQ   <= '0;
            resultQ  <= '0;
        end else begin
            cntQ     <= cntD;
            remQ     <= remD;
            quotQ    <= quotD;
            divisorQ <= divisorD;
            isRemQ   <= isRemD;
            quotNegQ <= quotNegD;
            remNegQ  <= remNegD;
            rdQ      <= rdD;
            rdOutQ   <= rdOutD;
            resultQ  <= resultD;
        end
    end

    assign ResultF = resultQ;
    assign RdF     = rdOutQ;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, randomized ops against an
// arithmetic reference model, kill, mid-op reset and back-to-back issue.
module tb_div_unit;

    localparam int unsigned XLEN = 32;

    logic        clk, rst_n, StartE, KillF, BusyF, DoneF;
    logic [1:0]  DivOpE;
    logic [31:0] SrcAE, SrcBE, ResultF;
    logic [4:0]  RdE, RdF;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] lastRes;
    logic [4:0]  lastRd;

    div_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .StartE (StartE),
        .DivOpE (DivOpE),
        .SrcAE  (SrcAE),
        .SrcBE  (SrcBE),
        .RdE    (RdE),
        .KillF  (KillF),
        .BusyF  (BusyF),
        .DoneF  (DoneF),
        .ResultF(ResultF),
        .RdF    (RdF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'h0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Issue one op this cycle and observe it through completion (no checking here).
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit noise,
                         output int lat, output int busyCycles, output logic busyAtDone,
                         output logic [31:0] res, output logic [4:0] rdOut,
                         output logic doneAfter);
        StartE = 1'b1;
        KillF  = 1'b0;
        DivOpE = op;
        SrcAE  = a;
        SrcBE  = b;
        RdE    = rd;
        #1;
        busyCycles = (BusyF === 1'b1) ? 1 : 0;
        lat = 0;
        while (lat < 200) begin
            tick();
            lat++;
            if (DoneF === 1'b1) break;
            if (BusyF === 1'b1) busyCycles++;
            StartE = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            DivOpE = 2'($urandom);
            SrcAE  = $urandom;
            SrcBE  = $urandom;
            RdE    = 5'($urandom);
        end
        busyAtDone = BusyF;
        res        = ResultF;
        rdOut      = RdF;
        StartE     = 1'b0;
        tick();
        doneAfter = DoneF;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        StartE = 1'b1;
        KillF  = 1'b0;
        DivOpE = 2'b01;
        SrcAE  = 32'd100;
        SrcBE  = 32'd7;
        RdE    = 5'd3;
        tick();
        tick();
        checks++;
        if (BusyF !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", BusyF);
        end
        checks++;
        if (DoneF !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b expected 0", DoneF);
        end
        checks++;
        if (ResultF !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 0", ResultF);
        end
        checks++;
        if (RdF !== 5'd0) begin
            errors++;
            $display("FAIL reset_rd: got %0d expected 0", RdF);
        end
        StartE = 1'b0;
        rst_n  = 1'b1;
        tick();
        lastRes = 32'h0;
        lastRd  = 5'd0;
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        logic [7:0]  lat;
    } vec_t;

    task automatic test_directed();
        vec_t vecs [9];
        int lat, busy;
        logic bad, dn2;
        logic [31:0] res;
        logic [4:0] rdo;
        vecs = '{
            '{2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 8'd33},
            '{2'b11, 32'd100, 32'd7, 5'd5, 32'd2, 8'd33},
            '{2'b00, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 8'd33},
            '{2'b10, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 8'd33},
            '{2'b00, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, 8'd33},
            '{2'b01, 32'h1234, 32'h0, 5'd9, 32'hFFFF_FFFF, 8'd1},
            '{2'b10, 32'h1234, 32'h0, 5'd10, 32'h1234, 8'd1},
            '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 8'd1},
            '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0, 8'd1}
        };
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, bit'(i % 2), lat, busy, bad,
                  res, rdo, dn2);
            checks++;
            if (lat !== int'(vecs[i].lat)) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, vecs[i].lat);
            end
            checks++;
            if (busy !== int'(vecs[i].lat)) begin
                errors++;
                $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, busy, vecs[i].lat);
            end
            checks++;
            if (bad !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_busy_at_done: got %b expected 0", i, bad);
            end
            checks++;
            if (res !== vecs[i].exp) begin
                errors++;
                $display("FAIL dir%0d_result: got %h expected %h", i, res, vecs[i].exp);
            end
            checks++;
            if (rdo !== vecs[i].rd) begin
                errors++;
                $display("FAIL dir%0d_rd: got %0d expected %0d", i, rdo, vecs[i].rd);
            end
            checks++;
            if (dn2 !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_done_pulse: got %b expected 0", i, dn2);
            end
            lastRes = vecs[i].exp;
            lastRd  = vecs[i].rd;
        end
    endtask

    task automatic test_random();
        int lat, busy;
        logic bad, dn2;
        logic [31:0] res, a, b, exp;
        logic [4:0] rdo, rd;
        logic [1:0] op;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom);
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            rd  = 5'($urandom);
            exp = ref_result(op, a, b);
            do_op(op, a, b, rd, bit'($urandom_range(0, 1)), lat, busy, bad, res, rdo, dn2);
            checks++;
            if (lat !== ref_latency(op, a, b)) begin
                errors++;
                $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat,
                         ref_latency(op, a, b));
            end
            checks++;
            if (busy !== ref_latency(op, a, b) || bad !== 1'b0) begin
                errors++;
                $display("FAIL rnd%0d_busy: got %0d/%b expected %0d/0", i, busy, bad,
                         ref_latency(op, a, b));
            end
            checks++;
            if (res !== exp) begin
                errors++;
                $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h expected %h", i, op, a, b,
                         res, exp);
            end
            checks++;
            if (rdo !== rd || dn2 !== 1'b0) begin
                errors++;
                $display("FAIL rnd%0d_rd_pulse: got rd=%0d done=%b expected rd=%0d done=0", i,
                         rdo, dn2, rd);
            end
            lastRes = exp;
            lastRd  = rd;
        end
    endtask

    task automatic test_kill();
        int lat, busy, doneSeen, busySeen;
        logic bad, dn2;
        logic [31:0] res;
        logic [4:0] rdo;
        // Kill a normal op at T+10.
        StartE = 1'b1;
        KillF  = 1'b0;
        DivOpE = 2'b01;
        SrcAE  = 32'd1000;
        SrcBE  = 32'd3;
        RdE    = 5'd9;
        tick();
        StartE = 1'b0;
        repeat (9) tick();
        KillF = 1'b1;
        tick();
        KillF = 1'b0;
        #1;
        checks++;
        if (BusyF !== 1'b0 || DoneF !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle: got busy=%b done=%b expected 0/0", BusyF, DoneF);
        end
        checks++;
        if (ResultF !== lastRes) begin
            errors++;
            $display("FAIL kill_result_held: got %h expected %h", ResultF, lastRes);
        end
        do_op(2'b01, 32'd1000, 32'd3, 5'd11, 1'b0, lat, busy, bad, res, rdo, dn2);
        checks++;
        if (lat !== 33 || res !== 32'd333 || rdo !== 5'd11) begin
            errors++;
            $display("FAIL kill_restart: got lat=%0d res=%h rd=%0d expected 33/14d/11", lat,
                     res, rdo);
        end
        lastRes = 32'd333;
        lastRd  = 5'd11;
        // StartE together with KillF in IDLE is rejected.
        StartE = 1'b1;
        KillF  = 1'b1;
        SrcBE  = 32'd5;
        #1;
        checks++;
        if (BusyF !== 1'b0) begin
            errors++;
            $display("FAIL kill_start_busy: got %b expected 0", BusyF);
        end
        tick();
        StartE   = 1'b0;
        KillF    = 1'b0;
        doneSeen = 0;
        busySeen = 0;
        repeat (40) begin
            tick();
            if (DoneF === 1'b1) doneSeen++;
            if (BusyF === 1'b1) busySeen++;
        end
        checks++;
        if (doneSeen !== 0 || busySeen !== 0) begin
            errors++;
            $display("FAIL kill_start_rejected: got done=%0d busy=%0d expected 0/0", doneSeen,
                     busySeen);
        end
    endtask

    task automatic test_reset_mid();
        int doneSeen;
        StartE = 1'b1;
        KillF  = 1'b0;
        DivOpE = 2'b00;
        SrcAE  = $urandom;
        SrcBE  = 32'd13;
        RdE    = 5'd17;
        tick();
        StartE = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        StartE = 1'b1;
        #1;
        checks++;
        if (BusyF !== 1'b0 || DoneF !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags: got busy=%b done=%b expected 0/0", BusyF, DoneF);
        end
        checks++;
        if (ResultF !== 32'h0 || RdF !== 5'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h/%0d expected 0/0", ResultF, RdF);
        end
        StartE   = 1'b0;
        rst_n    = 1'b1;
        doneSeen = 0;
        repeat (40) begin
            tick();
            if (DoneF === 1'b1) doneSeen++;
        end
        checks++;
        if (doneSeen !== 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d pulses expected 0", doneSeen);
        end
        lastRes = 32'h0;
        lastRd  = 5'd0;
    endtask

    task automatic test_back_to_back();
        int lat, busy;
        logic bad, dn2;
        logic [31:0] res, a1, b1, a2, b2;
        logic [4:0] rdo;
        a1 = $urandom;
        b1 = $urandom >> 20;
        a2 = $urandom;
        b2 = 32'h0;
        do_op(2'b10, a1, b1, 5'd20, 1'b1, lat, busy, bad, res, rdo, dn2);
        checks++;
        if (lat !== ref_latency(2'b10, a1, b1) || res !== ref_result(2'b10, a1, b1)) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d res=%h expected %0d/%h", lat, res,
                     ref_latency(2'b10, a1, b1), ref_result(2'b10, a1, b1));
        end
        do_op(2'b11, a2, b2, 5'd21, 1'b0, lat, busy, bad, res, rdo, dn2);
        checks++;
        if (lat !== 1 || res !== a2 || rdo !== 5'd21) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d res=%h rd=%0d expected 1/%h/21", lat, res,
                     rdo, a2);
        end
        repeat (3) tick();
        checks++;
        if (ResultF !== a2 || RdF !== 5'd21) begin
            errors++;
            $display("FAIL b2b_hold: got %h/%0d expected %h/21", ResultF, RdF, a2);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
